// File: rtl/icache_refill_fetch.sv
// Fetch controller in front of a direct-mapped I-cache: hit returns the word, miss refills a block byte-serially.
// Define ICACHE_REFILL_FORWARD_EN to deliver the missed word straight from the assembled block in the WRITE cycle.
module icache_refill_fetch #(
  parameter int BLOCK_BYTES = 16,
  parameter int BLOCK_BITS  = BLOCK_BYTES * 8,
  parameter int OFF_W       = $clog2(BLOCK_BYTES)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_addr,
  output logic                  inst_valid,
  output logic [31:0]           inst_out,
  output logic [31:0]           inst_pc,
  output logic [31:0]           cache_addr,
  input  logic                  cache_hit,
  input  logic [31:0]           cache_inst,
  output logic                  cache_we,
  output logic [BLOCK_BITS-1:0] cache_block,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_gnt,
  input  logic [7:0]            mem_din
);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  localparam logic [OFF_W:0] ONE      = (OFF_W+1)'(1);
  localparam logic [OFF_W:0] BB_CNT   = (OFF_W+1)'(BLOCK_BYTES);
  localparam logic [OFF_W:0] LAST_CNT = BB_CNT - ONE;

  state_t         state, state_nxt;
  logic [31:0]    base;
  logic [OFF_W:0] issue_cnt;
  logic [OFF_W:0] recv_cnt;
  logic           rd_pending;
  logic           accept;

  assign accept     = fetch_valid && !inst_valid && !flush;
  assign cache_addr = (state == IDLE) ? fetch_addr : base;
  // Block base has zero offset bits, so OR-ing the count never carries out of the block.
  assign mem_addr   = {base[31:OFF_W], issue_cnt[OFF_W-1:0]};

  always_comb begin
    state_nxt = state;
    cache_we  = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !cache_hit) state_nxt = REFILL;
      end
      REFILL: begin
        mem_req = (issue_cnt < BB_CNT);
        if (rd_pending && (recv_cnt == LAST_CNT)) state_nxt = WRITE;
      end
      WRITE: begin
        cache_we  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      cache_we  = 1'b0;
      mem_req   = 1'b0;
    end
    // A frozen cycle must not strobe the cache or hand an address to the arbiter.
    if (!rdy_in) begin
      state_nxt = state;
      cache_we  = 1'b0;
      mem_req   = 1'b0;
    end
  end

`ifdef ICACHE_REFILL_FORWARD_EN
  logic [31:0]      fwd_word;
  logic [OFF_W-1:0] fwd_idx;

  always_comb begin
    fwd_word = '0;
    fwd_idx  = '0;
    for (int k = 0; k < 4; k++) begin
      fwd_idx = fetch_addr[OFF_W-1:0] + OFF_W'(k);
      fwd_word[8*k +: 8] = cache_block[{fwd_idx, 3'b000} +: 8];
    end
  end
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      base        <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      rd_pending  <= 1'b0;
      cache_block <= '0;
      inst_valid  <= 1'b0;
      inst_out    <= '0;
      inst_pc     <= '0;
    end else if (rdy_in) begin
      state      <= state_nxt;
      inst_valid <= 1'b0;
      rd_pending <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (cache_hit) begin
                inst_valid <= 1'b1;
                inst_out   <= cache_inst;
                inst_pc    <= fetch_addr;
              end else begin
                base      <= {fetch_addr[31:OFF_W], {OFF_W{1'b0}}};
                issue_cnt <= '0;
                recv_cnt  <= '0;
              end
            end
          end
          REFILL: begin
            if (mem_req && mem_gnt) begin
              issue_cnt  <= issue_cnt + ONE;
              rd_pending <= 1'b1;
            end
            if (rd_pending) begin
              cache_block[{recv_cnt[OFF_W-1:0], 3'b000} +: 8] <= mem_din;
              recv_cnt <= recv_cnt + ONE;
            end
          end
          WRITE: begin
`ifdef ICACHE_REFILL_FORWARD_EN
            inst_valid <= 1'b1;
            inst_out   <= fwd_word;
            inst_pc    <= fetch_addr;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_fetch.sv
// Directed bench for icache_refill_fetch; expectations follow ICACHE_REFILL_FORWARD_EN when defined.
module tb_icache_refill_fetch;

`ifdef ICACHE_REFILL_FORWARD_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 20;
`endif

  logic         clk_in = 1'b0;
  logic         rst_in, rdy_in, flush, fetch_valid;
  logic [31:0]  fetch_addr;
  logic         inst_valid;
  logic [31:0]  inst_out, inst_pc, cache_addr;
  logic         cache_hit;
  logic [31:0]  cache_inst;
  logic         cache_we;
  logic [127:0] cache_block;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt;
  logic [7:0]   mem_din, mem_q, salt;
  logic         noise_en;
  int           n_chk = 0;
  int           n_fail = 0;

  icache_refill_fetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_inst(cache_inst),
    .cache_we(cache_we), .cache_block(cache_block),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_din(mem_din)
  );

  always #5 clk_in = ~clk_in;

  // Memory returns (byte offset + salt) one cycle after a granted address.
  always @(posedge clk_in)
    if (rdy_in && mem_req && mem_gnt) mem_q <= {4'h0, mem_addr[3:0]} + salt;
  assign mem_din = noise_en ? 8'hA5 : mem_q;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_block(input logic [7:0] s);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[8*i +: 8] = 8'(i) + s;
    return b;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a, input logic [7:0] s);
`ifdef ICACHE_REFILL_FORWARD_EN
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = {4'h0, a[3:0]} + 8'(k) + s;
    return w;
`else
    return (a[0] === 1'bx) ? 32'h0 : 32'hDEADBEEF;
`endif
  endfunction

  task automatic refill_run(input logic [31:0] addr, input logic alt, input int frz_at,
                            input int exp_lat, input logic [7:0] s);
    logic [127:0] snap_blk;
    logic [31:0]  snap_addr, base_e;
    int n_we, n_iss, n_bad, lat;
    bit frozen, done;
    base_e = {addr[31:4], 4'h0};
    n_we = 0; n_iss = 0; n_bad = 0; lat = -1; done = 0;
    snap_blk = '0; snap_addr = '0;
    step();
    salt = s; fetch_valid = 1'b1; fetch_addr = addr; cache_hit = 1'b0;
    cache_inst = 32'hDEADBEEF; mem_gnt = 1'b1;
    #1 check("lookup_addr", cache_addr, addr);
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      step();
      frozen = (frz_at > 0) && (cyc >= frz_at) && (cyc < frz_at + 3);
      rdy_in = !frozen;
      noise_en = frozen;
      mem_gnt = (frozen || alt) ? cyc[0] : 1'b1;
      #1;
      if (cyc == frz_at) begin snap_blk = cache_block; snap_addr = mem_addr; end
      if (frz_at > 0 && cyc > frz_at && cyc <= frz_at + 3) begin
        check("frz_block", cache_block, snap_blk);
        check("frz_mem_addr", mem_addr, snap_addr);
      end
      if (mem_req && mem_gnt) begin
        if (mem_addr !== base_e + 32'(n_iss)) n_bad++;
        n_iss++;
      end
      if (cache_we) begin
        n_we++;
        check("we_cache_addr", cache_addr, base_e);
        check("we_block", cache_block, exp_block(s));
        cache_hit = 1'b1;
      end
      if (inst_valid) begin
        lat = cyc; done = 1;
        check("miss_inst_out", inst_out, exp_inst(addr, s));
        check("miss_inst_pc", inst_pc, addr);
      end
    end
    fetch_valid = 1'b0; cache_hit = 1'b0; rdy_in = 1'b1; noise_en = 1'b0; mem_gnt = 1'b0;
    check("we_count", n_we, 1);
    check("issue_count", n_iss, 16);
    check("issue_addr_errs", n_bad, 0);
    check("miss_latency", lat, exp_lat);
  endtask

  initial begin
    int n;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_addr = '0;
    cache_hit = 1'b0; cache_inst = '0; mem_gnt = 1'b0; salt = '0; noise_en = 1'b0;
    #12;
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_cache_we", cache_we, 0);
    check("rst_block", cache_block, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    step();
    rst_in = 1'b0;
    step();

    // Hit path
    fetch_valid = 1'b1; fetch_addr = 32'h100; cache_hit = 1'b1; cache_inst = 32'h13;
    #1 check("idle_cache_addr", cache_addr, 32'h100);
    step();
    check("hit_valid", inst_valid, 1);
    check("hit_inst", inst_out, 32'h13);
    check("hit_pc", inst_pc, 32'h100);
    check("hit_no_mem_req", mem_req, 0);
    step();
    check("hit_pulse_no_accept", inst_valid, 0);
    fetch_valid = 1'b0; cache_hit = 1'b0;

    refill_run(32'h1234, 1'b0, 0, LAT, 8'h00);
    refill_run(32'h1234, 1'b1, 0, LAT + 15, 8'h10);

    // Flush after five granted bytes
    step();
    fetch_valid = 1'b1; fetch_addr = 32'h1234; cache_hit = 1'b0; mem_gnt = 1'b1; salt = 8'h40;
    repeat (6) step();
    check("pre_flush_req", mem_req, 1);
    check("pre_flush_addr", mem_addr, 32'h1235);
    flush = 1'b1; fetch_valid = 1'b0;
    #1 check("flush_req_gate", mem_req, 0);
    step();
    flush = 1'b0;
    #1 check("post_flush_req", mem_req, 0);
    n = 0;
    repeat (20) begin step(); if (cache_we) n++; end
    check("flush_no_we", n, 0);
    refill_run(32'h2000, 1'b0, 0, LAT, 8'h20);

    refill_run(32'h1234, 1'b0, 8, LAT + 3, 8'h30);
    refill_run(32'h1236, 1'b0, 0, LAT, 8'h00);

    // Reset in the middle of a refill
    step();
    fetch_valid = 1'b1; fetch_addr = 32'h3000; cache_hit = 1'b0; mem_gnt = 1'b1;
    repeat (4) step();
    rst_in = 1'b1;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_block", cache_block, 0);
    step();
    rst_in = 1'b0; fetch_valid = 1'b0;
    n = 0;
    repeat (20) begin step(); if (cache_we) n++; end
    check("midrst_no_we", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill_fetch.md
Name: icache_refill_fetch

Overview:
- Fetch-side controller directly upstream of the direct-mapped instruction cache.
- Takes PC requests from the instruction-fetch stage and looks each one up in the cache.
- On a hit it returns the 32-bit instruction.
- On a miss it reads the whole cache block from memory one byte per cycle through the memory arbiter, assembles it, writes it into the cache with a one-cycle write strobe, and then re-looks-up.

Parameters:
- BLOCK_BYTES, 16: bytes per cache block; power of two, at least 4.
- BLOCK_BITS, BLOCK_BYTES*8: width of the assembled block bus.
- OFF_W, log2(BLOCK_BYTES): byte-offset field width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; asynchronous, active-high.
- rdy_in  in  1  global ready; low freezes the block.
- flush  in  1  branch redirect; aborts any request.
- fetch_valid  in  1  a PC request is pending.
- fetch_addr  in  32  requested PC; held stable until inst_valid.
- inst_valid  out  1  one-cycle pulse: instruction delivered.
- inst_out  out  32  delivered instruction.
- inst_pc  out  32  PC of the delivered instruction.
- cache_addr  out  32  address to the cache (lookup and write).
- cache_hit  in  1  cache hit for cache_addr.
- cache_inst  in  32  cache instruction for cache_addr.
- cache_we  out  1  cache write strobe.
- cache_block  out  BLOCK_BITS  assembled block; byte i occupies bits [8i+7:8i].
- mem_req  out  1  byte-read request to the arbiter.
- mem_addr  out  32  byte address being issued.
- mem_gnt  in  1  arbiter accepted mem_addr this cycle.
- mem_din  in  8  read data; returns one cycle after the granted address.

Behaviour:
- Reset (asynchronous): state IDLE; inst_valid=0, inst_out=0, inst_pc=0, cache_we=0, cache_block=0, mem_req=0, mem_addr=0; counters and rd_pending cleared.
- rdy_in=0: every register holds its value and all inputs are ignored, including mem_gnt, mem_din and flush.
- flush=1 (rdy_in=1): next state IDLE; inst_valid=0, mem_req=0, cache_we=0. Any partial block and in-flight byte are discarded and the cache is not written. flush has priority over every other event.
- cache_addr: equals fetch_addr in IDLE; equals the registered block base in REFILL and WRITE.
- IDLE:
  - Accept a request when fetch_valid=1, inst_valid=0 and flush=0.
  - Hit: register inst_valid=1, inst_out=cache_inst, inst_pc=fetch_addr. Hit latency is 1 cycle.
  - Miss: base = fetch_addr with the low OFF_W bits cleared; issue_cnt=0, recv_cnt=0; go to REFILL.
  - inst_valid is a single-cycle pulse. No new request is accepted in the cycle it is high, so hit throughput is one per 2 cycles.
- REFILL:
  - mem_req=1 while issue_cnt<BLOCK_BYTES; mem_addr=base+issue_cnt.
  - A cycle with mem_gnt=1 increments issue_cnt and sets rd_pending for the next cycle.
  - A cycle with rd_pending=1 stores mem_din into byte recv_cnt of cache_block and increments recv_cnt.
  - mem_gnt=0 stalls issuing only; a byte already in flight is still captured.
  - When the last byte is captured (recv_cnt reaches BLOCK_BYTES), go to WRITE.
- WRITE: cache_we=1 for exactly one cycle with cache_addr=base, then IDLE. The request is still pending, so the re-lookup hits.
- Miss latency with uninterrupted grant: miss seen in cycle t, bytes issued t+1..t+BLOCK_BYTES, WRITE at t+BLOCK_BYTES+2, inst_valid at t+BLOCK_BYTES+4 (t+20 for BLOCK_BYTES=16).
- Address arithmetic: mod 2^32; base+issue_cnt never crosses the block.
- Reset mid-REFILL: immediate return to IDLE; the cache is not written.

Optional Feature:
- ICACHE_REFILL_FORWARD_EN, defined: in the WRITE cycle also register inst_valid=1, inst_pc=fetch_addr, and inst_out = the 32 bits of cache_block starting at byte fetch_addr[OFF_W-1:0] (little-endian). The controller then returns to IDLE with inst_valid high, so no re-lookup occurs. Miss latency becomes BLOCK_BYTES+3.
- ICACHE_REFILL_FORWARD_EN, undefined: behaviour exactly as in Behaviour above.

Test Plan:
- Reset, then fetch_valid=1, fetch_addr=0x100, cache_hit=1, cache_inst=0x00000013 -> inst_valid for one cycle with inst_out=0x00000013, inst_pc=0x100; no accept in that cycle.
- Miss at 0x1234, mem_gnt=1, mem_din=byte index -> mem_addr 0x1230..0x123F; cache_we one cycle with cache_addr=0x1230 and cache_block=0x0F0E..0100; inst_valid 20 cycles after the miss.
- Same miss with mem_gnt low every other cycle -> bytes still assembled in order; exactly one cache_we; no dropped in-flight byte.
- flush asserted after 5 granted bytes -> mem_req drops next cycle; no cache_we; a new request at 0x2000 starts a fresh refill from 0x2000.
- rdy_in low for 3 cycles mid-REFILL while mem_din and mem_gnt toggle -> state, counters and block unchanged; the refill completes identically afterwards.
- Macro defined, miss at 0x1236 -> inst_valid in the WRITE cycle+1 with inst_out=0x09080706, latency 19.
